// File: rtl/axi_stream_insert_header_pkg.sv
// Shared types and byte-count helpers for the header-insert stream repacker.
package axi_stream_insert_header_pkg;

    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    function automatic int popcount(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) n += keep[i] ? 1 : 0;
        return n;
    endfunction

    // n ones at the top of an nbytes-wide field; n <= 0 gives an empty mask
    function automatic logic [MAX_BYTES-1:0] msb_keep(input int n, input int nbytes);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) k[i] = (i < nbytes) && (i >= nbytes - n);
        return k;
    endfunction

endpackage

// File: rtl/axis_byte_merger.sv
// Combinational merge of the right-aligned residual bytes with one input beat.
module axis_byte_merger
    import axi_stream_insert_header_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CW           = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0]      res,
    input  logic [DATA_WD-1:0]      data,
    input  logic [CW-1:0]           h,
    input  logic [CW-1:0]           k,
    input  logic                    last,
    output logic [DATA_WD-1:0]      data_o,
    output logic [DATA_BYTE_WD-1:0] keep_o,
    output logic [DATA_WD-1:0]      res_next,
    output logic                    ovf,
    output logic [DATA_BYTE_WD-1:0] ovf_keep
);

    logic [2*DATA_WD-1:0]    wide;
    logic [CW:0]             t;
    logic [DATA_BYTE_WD-1:0] keep_t;
    logic [DATA_WD-1:0]      mask_t, mask_v;

    always_comb begin
        // residual's h low bytes land at the top, followed by the whole input beat
        wide     = {res, data} << (8 * (DATA_BYTE_WD - int'(h)));
        t        = {1'b0, h} + {1'b0, k};
        ovf      = last && (int'(t) > DATA_BYTE_WD);
        keep_t   = DATA_BYTE_WD'(msb_keep(int'(t), DATA_BYTE_WD));
        ovf_keep = DATA_BYTE_WD'(msb_keep(int'(t) - DATA_BYTE_WD, DATA_BYTE_WD));
        mask_t   = '0;
        mask_v   = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            mask_t[8*b +: 8] = {8{keep_t[b]}};
            mask_v[8*b +: 8] = {8{ovf_keep[b]}};
        end
        data_o   = wide[2*DATA_WD-1 -: DATA_WD];
        keep_o   = '1;
        res_next = data;
        if (ovf) begin
            res_next = wide[DATA_WD-1:0] & mask_v;
        end else if (last) begin
            keep_o = keep_t;
            data_o = data_o & mask_t;
        end
    end

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends the valid bytes of a side-channel header to each AXI-Stream packet, repacking to full beats.
module axi_stream_insert_header
    import axi_stream_insert_header_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      header_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert
);

    localparam int CW = $clog2(DATA_BYTE_WD + 1);

    state_t                  state, state_next;
    logic [DATA_WD-1:0]      res;
    logic [CW-1:0]           h, h_new, k_in;
    logic [DATA_BYTE_WD-1:0] flush_keep;
    logic [DATA_WD-1:0]      m_data, m_res;
    logic [DATA_BYTE_WD-1:0] m_keep, m_ovf_keep;
    logic                    m_ovf;
    logic                    load_data, load_flush;

    assign k_in       = CW'(popcount(MAX_BYTES'(keep_in)));
    assign h_new      = CW'(popcount(MAX_BYTES'(keep_insert)));
    assign load_data  = valid_in && ready_in;
    assign load_flush = (state == FLUSH) && (!valid_out || ready_out);

    axis_byte_merger #(.DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD), .CW(CW)) u_merger (
        .res      (res),
        .data     (data_in),
        .h        (h),
        .k        (k_in),
        .last     (last_in),
        .data_o   (m_data),
        .keep_o   (m_keep),
        .res_next (m_res),
        .ovf      (m_ovf),
        .ovf_keep (m_ovf_keep)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        case (state)
            IDLE: begin
                ready_insert = 1'b1;
                if (valid_insert) state_next = STREAM;
            end
            STREAM: begin
                ready_in = !valid_out || ready_out;
                if (valid_in && ready_in && last_in) state_next = m_ovf ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (!valid_out || ready_out) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
            res        <= '0;
            h          <= '0;
            flush_keep <= '0;
        end else begin
            if (state == IDLE && valid_insert) begin
                res <= header_insert;
                h   <= h_new;
            end
            if (load_data) begin
                res <= m_res;
                if (m_ovf) flush_keep <= m_ovf_keep;
            end
            if (load_data) begin
                valid_out <= 1'b1;
                data_out  <= m_data;
                keep_out  <= m_keep;
                last_out  <= last_in && !m_ovf;
            end else if (load_flush) begin
                // leftover bytes are already left-aligned and masked in res
                valid_out <= 1'b1;
                data_out  <= res;
                keep_out  <= flush_keep;
                last_out  <= 1'b1;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed + randomized bench for axi_stream_insert_header against a byte-queue reference model.
module tb_axi_stream_insert_header;

    localparam int W = 32;
    localparam int N = W / 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic [N-1:0] k;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0, last_in = 1'b0, ready_in;
    logic [W-1:0] data_in = '0;
    logic [N-1:0] keep_in = '0;
    logic         valid_out, last_out;
    logic [W-1:0] data_out;
    logic [N-1:0] keep_out;
    logic         ready_out = 1'b1;
    logic         valid_insert = 1'b0, ready_insert;
    logic [W-1:0] header_insert = '0;
    logic [N-1:0] keep_insert = '0;

    beat_t        exp_q[$];
    logic [W-1:0] din_q[$];
    int           checks = 0, errors = 0;
    int           mode = 0;
    bit           hold = 0;
    bit           hs_ins, hs_in, rin_s, vout_s, rins_s, hold_chk;
    beat_t        hold_b;

    always #5 clk = ~clk;

    axi_stream_insert_header #(.DATA_WD(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .keep_in       (keep_in),
        .last_in       (last_in),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .keep_out      (keep_out),
        .last_out      (last_out),
        .ready_out     (ready_out),
        .valid_insert  (valid_insert),
        .header_insert (header_insert),
        .keep_insert   (keep_insert),
        .ready_insert  (ready_insert)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_push(input logic [W-1:0] d, input logic [N-1:0] k, input logic l);
        beat_t e;
        e.d = d; e.k = k; e.l = l;
        exp_q.push_back(e);
    endfunction

    // Packet as a flat byte stream: header low bytes then data bytes, re-chunked into N-byte beats
    function automatic void model_push(input logic [W-1:0] hdr, input logic [N-1:0] hk,
                                       input logic [N-1:0] lk);
        logic [7:0]   bq[$];
        beat_t        e;
        logic [W-1:0] w;
        int           hc, lc, cnt, n;
        hc = $countones(hk);
        lc = $countones(lk);
        for (int i = hc - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
        for (int j = 0; j < din_q.size(); j++) begin
            w   = din_q[j];
            cnt = (j == din_q.size() - 1) ? lc : N;
            for (int b = 0; b < cnt; b++) bq.push_back(w[W-1-8*b -: 8]);
        end
        while (bq.size() > 0) begin
            e = '0;
            n = (bq.size() < N) ? bq.size() : N;
            for (int b = 0; b < n; b++) begin
                e.d[W-1-8*b -: 8] = bq.pop_front();
                e.k[N-1-b] = 1'b1;
            end
            e.l = (bq.size() == 0);
            exp_q.push_back(e);
        end
    endfunction

    task automatic cycle();
        beat_t o, e;
        @(negedge clk);
        hs_ins = valid_insert && ready_insert;
        hs_in  = valid_in && ready_in;
        rin_s  = ready_in;
        vout_s = valid_out;
        rins_s = ready_insert;
        o = {data_out, keep_out, last_out};
        if (hold_chk) chk("hold_stable", 64'(o), 64'(hold_b));
        chk("ready_in_rule", 64'(ready_in && valid_out && !ready_out), 64'(0));
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(o), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(data_out), 64'(e.d));
                chk("out_keep", 64'(keep_out), 64'(e.k));
                chk("out_last", 64'(last_out), 64'(e.l));
            end
        end
        hold_chk = valid_out && !ready_out;
        hold_b   = o;
        @(posedge clk);
        #1;
        case (mode)
            0:       ready_out = 1'b1;
            1:       ready_out = !ready_out;
            2:       ready_out = 1'($urandom_range(0, 1));
            default: ready_out = 1'b0;
        endcase
    endtask

    task automatic send_pkt(input logic [W-1:0] hdr, input logic [N-1:0] hk, input logic [N-1:0] lk,
                            input bit use_model, input bit lat);
        int t, nb;
        nb = din_q.size();
        if (use_model) model_push(hdr, hk, lk);
        valid_insert = 1'b1; header_insert = hdr; keep_insert = hk;
        t = 0;
        do begin
            cycle(); t++;
            if (hold) chk("idle_no_accept", 64'(hs_in), 64'(0));
        end while (!hs_ins && t < 50);
        chk("hdr_accept", 64'(hs_ins), 64'(1));
        valid_insert = 1'b0; header_insert = $urandom(); keep_insert = '1;
        for (int j = 0; j < nb; j++) begin
            valid_in = 1'b1; data_in = din_q[j]; last_in = (j == nb - 1);
            keep_in  = last_in ? lk : '1;
            t = 0;
            do begin
                cycle(); t++;
                if (lat && t == 1 && j == 0) chk("hdr_no_out", 64'(vout_s), 64'(0));
                if (lat && t == 1 && j == 1) chk("first_latency", 64'(vout_s), 64'(1));
            end while (!hs_in && t < 50);
            chk("beat_accept", 64'(hs_in), 64'(1));
        end
        if (hold) begin
            valid_in = 1'b1; data_in = '0; keep_in = '1; last_in = 1'b0;
        end else begin
            valid_in = 1'b0; last_in = 1'b0;
        end
        if ($countones(hk) + $countones(lk) > N) begin
            cycle();
            chk("flush_ready_in", 64'(rin_s), 64'(0));
        end
        din_q.delete();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin cycle(); t++; end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic test1_stim(input bit lat);
        din_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        exp_push(32'hCCDD1122, 4'hF, 1'b0);
        exp_push(32'h33445566, 4'hF, 1'b0);
        exp_push(32'h778899AA, 4'hF, 1'b1);
        send_pkt(32'hAABBCCDD, 4'b0011, 4'b1100, 1'b0, lat);
        drain();
    endtask

    initial begin
        int hc, nb, lc;
        logic [N-1:0] hk, lk, f;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("rst_valid_out", 64'(vout_s), 64'(0));
        chk("rst_ready_insert", 64'(rins_s), 64'(1));
        chk("rst_ready_in", 64'(rin_s), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_keep_out", 64'(keep_out), 64'(0));
        chk("rst_last_out", 64'(last_out), 64'(0));

        // 1: two header bytes, exact fit on last beat
        test1_stim(1'b1);

        // 2: three header bytes, overflow into a flush beat
        din_q = '{32'hB0B1B2B3, 32'hC0C1C2C3};
        exp_push(32'hA1A2A3B0, 4'hF, 1'b0);
        exp_push(32'hB1B2B3C0, 4'hF, 1'b0);
        exp_push(32'hC1C20000, 4'b1100, 1'b1);
        send_pkt(32'h00A1A2A3, 4'b0111, 4'b1110, 1'b0, 1'b0);
        drain();

        // 3: full header word, then empty header
        din_q = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243, 32'h50515253};
        send_pkt(32'h01020304, 4'b1111, 4'b1000, 1'b1, 1'b0);
        din_q = '{32'h61626364, 32'h71727374, 32'h81828384};
        send_pkt(32'hFFFFFFFF, 4'b0000, 4'b1110, 1'b1, 1'b0);
        drain();

        // 4: sink backpressure toggling every cycle
        mode = 1;
        test1_stim(1'b0);
        mode = 0;

        // 5: valid_in held high between back-to-back packets
        hold = 1;
        for (int p = 0; p < 3; p++) begin
            din_q = '{$urandom(), $urandom()};
            send_pkt($urandom(), 4'b0111 >> p, 4'b1110 << p, 1'b1, 1'b0);
        end
        hold = 0;
        valid_in = 1'b0;
        drain();

        // 6: reset mid-packet with output stalled
        mode = 3;
        ready_out = 1'b0;
        din_q = '{$urandom(), $urandom(), $urandom()};
        valid_insert = 1'b1; header_insert = 32'hDEADBEEF; keep_insert = 4'b0111;
        do cycle(); while (!hs_ins);
        valid_insert = 1'b0;
        valid_in = 1'b1; data_in = din_q[0]; keep_in = '1; last_in = 1'b0;
        cycle();
        chk("pre_rst_accept", 64'(hs_in), 64'(1));
        data_in = din_q[1];
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; valid_in = 1'b0; hold_chk = 1'b0;
        exp_q.delete(); din_q.delete();
        cycle();
        chk("midrst_valid_out", 64'(vout_s), 64'(0));
        chk("midrst_ready_insert", 64'(rins_s), 64'(1));
        chk("midrst_keep_out", 64'(keep_out), 64'(0));
        mode = 0;
        din_q = '{32'hA0A1A2A3, 32'hB0B1B2B3};
        send_pkt(32'h00000055, 4'b0001, 4'b1000, 1'b1, 1'b0);
        drain();

        // randomized packets with random backpressure
        mode = 2;
        for (int p = 0; p < 40; p++) begin
            hc = $urandom_range(0, N);
            hk = N'((1 << hc) - 1);
            lc = $urandom_range(1, N);
            f  = '1;
            lk = ~(f >> lc);
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) din_q.push_back($urandom());
            send_pkt($urandom(), hk, lk, 1'b1, 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
